// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus signal around the data-RAM arbiter: the core load/store
// request port, the UART loader request port, the shared read-data return,
// the boot status flag and the block-RAM drive/return signals.
//   slave  modport : seen by the arbiter (requests and RAM data in,
//                    grants, rvalids, rdata and RAM drive out)
//   master modport : seen by the environment (requesters plus block RAM)
// Parameter AW: byte-address width of both requesters and of the RAM.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int AW = 32
);
   // core load/store port
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [31:0]   core_wdata;
   logic          core_gnt;
   logic          core_stall;
   logic          core_rvalid;

   // loader port
   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_wdata;
   logic          ld_gnt;
   logic          ld_rvalid;
   logic          ld_done;

   // shared return and status
   logic [31:0]   rdata;
   logic          booting;

   // block RAM side
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_di;
   logic [31:0]   ram_dout;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
      input  ram_dout,
      output core_gnt, core_stall, core_rvalid,
      output ld_gnt, ld_rvalid,
      output rdata, booting,
      output ram_en, ram_we, ram_addr, ram_di
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
      output ram_dout,
      input  core_gnt, core_stall, core_rvalid,
      input  ld_gnt, ld_rvalid,
      input  rdata, booting,
      input  ram_en, ram_we, ram_addr, ram_di
   );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data block RAM between the core load/store stage and
// the UART program loader. While booting only the loader is served; after the
// loader signals ld_done the core has priority, except that a loader denied
// STARVE_MAX times in a row wins the next contended cycle. Read data from the
// RAM (one cycle latency) is broadcast on rdata and qualified by the rvalid of
// whichever requester issued the load.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - dmem_arbiter_if.slave: core/loader request ports, grants, stall,
//          rvalids, rdata, booting flag and block-RAM drive/return
// Parameters:
//   STARVE_MAX - consecutive loader denials before the loader wins (1..15)
//   AW         - byte-address width
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic       OWNER_CORE = 1'b0;
   localparam logic       OWNER_LD   = 1'b1;

   state_t        state_r;
   logic [3:0]    starve_cnt_r;
   logic          rd_pend_r;
   logic          rd_owner_r;

   logic          core_gnt_s;
   logic          ld_gnt_s;
   logic          rd_issue_s;
   logic          ram_we_s;
   logic [AW-1:0] ram_addr_s;
   logic [31:0]   ram_di_s;

   // Grant decision: loader only while booting, core priority with a starvation escape afterwards.
   always_comb begin
      core_gnt_s = 1'b0;
      ld_gnt_s   = 1'b0;
      if (rst) begin
         core_gnt_s = 1'b0;
         ld_gnt_s   = 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               core_gnt_s = 1'b0;
               ld_gnt_s   = bus.ld_req;
            end
            ST_RUN: begin
               if (bus.core_req && bus.ld_req) begin
                  // contended: the loader only wins once it has waited its full allowance
                  if (starve_cnt_r == STARVE_LIM) begin
                     ld_gnt_s = 1'b1;
                  end else begin
                     core_gnt_s = 1'b1;
                  end
               end else begin
                  core_gnt_s = bus.core_req;
                  ld_gnt_s   = bus.ld_req;
               end
            end
            default: begin
               core_gnt_s = 1'b0;
               ld_gnt_s   = 1'b0;
            end
         endcase
      end
   end

   // RAM command mux from the granted requester; address/data are don't-care when idle.
   always_comb begin
      ram_we_s   = 1'b0;
      ram_addr_s = {AW{1'b0}};
      ram_di_s   = 32'd0;
      if (core_gnt_s) begin
         ram_we_s   = bus.core_we;
         ram_addr_s = bus.core_addr;
         ram_di_s   = bus.core_wdata;
      end else if (ld_gnt_s) begin
         ram_we_s   = bus.ld_we;
         ram_addr_s = bus.ld_addr;
         ram_di_s   = bus.ld_wdata;
      end else begin
         // park on the core fields so the address bus does not toggle needlessly
         ram_we_s   = 1'b0;
         ram_addr_s = bus.core_addr;
         ram_di_s   = bus.core_wdata;
      end
   end

   assign rd_issue_s = (core_gnt_s & ~bus.core_we) | (ld_gnt_s & ~bus.ld_we);

   // Boot/run state, loader starvation counter and pending-read tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_BOOT;
         starve_cnt_r <= 4'd0;
         rd_pend_r    <= 1'b0;
         rd_owner_r   <= OWNER_CORE;
      end else begin
         case (state_r)
            ST_BOOT: begin
               if (bus.ld_done) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_BOOT;
               end
            end
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= ST_BOOT;
         endcase

         // counts only denied loader cycles in RUN; any grant or idle cycle restarts it
         if ((state_r != ST_RUN) || !bus.ld_req || ld_gnt_s) begin
            starve_cnt_r <= 4'd0;
         end else if (starve_cnt_r < STARVE_LIM) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end

         rd_pend_r  <= rd_issue_s;
         rd_owner_r <= ld_gnt_s ? OWNER_LD : OWNER_CORE;
      end
   end

   assign bus.core_gnt    = core_gnt_s;
   assign bus.ld_gnt      = ld_gnt_s;
   assign bus.core_stall  = bus.core_req & ~core_gnt_s;
   assign bus.ram_en      = core_gnt_s | ld_gnt_s;
   assign bus.ram_we      = ram_we_s;
   assign bus.ram_addr    = ram_addr_s;
   assign bus.ram_di      = ram_di_s;
   // a reset landing on the return cycle discards the read
   assign bus.core_rvalid = rd_pend_r & (rd_owner_r == OWNER_CORE) & ~rst;
   assign bus.ld_rvalid   = rd_pend_r & (rd_owner_r == OWNER_LD) & ~rst;
   assign bus.rdata       = bus.ram_dout;
   assign bus.booting     = (state_r == ST_BOOT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Provides a 64-word block RAM stand-in,
// a behavioural reference model (boot flag, loader wait length, queue of
// expected read returns, expected memory image), a table of directed boot and
// read-routing vectors, hand-written corner sequences and a random phase.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
   localparam int SMAX = 4;
   localparam int AW   = 32;

   logic clk = 1'b0;
   logic rst;
   logic ram_clear;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW)) bus ();

   dmem_arbiter #(.STARVE_MAX(SMAX), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // block RAM stand-in: one-cycle read latency, write on enabled store
   logic [31:0] ram_mem [0:63];
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= 32'd0;
      end else if (bus.ram_en) begin
         if (bus.ram_we) ram_mem[bus.ram_addr[7:2]] <= bus.ram_di;
         else            bus.ram_dout <= ram_mem[bus.ram_addr[7:2]];
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      bit          owner;   // 0 core, 1 loader
      logic [31:0] data;
   } ret_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          m_run;
   int          m_wait;     // consecutive denied loader cycles in RUN
   logic [31:0] exp_mem [0:63];
   ret_t        pend_q [$];
   bit          e_cg, e_lg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_grants();
      e_cg = 1'b0;
      e_lg = 1'b0;
      if (rst) begin
         e_cg = 1'b0;
      end else if (!m_run) begin
         e_lg = bus.ld_req;
      end else if (bus.core_req && bus.ld_req) begin
         if (m_wait >= SMAX) e_lg = 1'b1;
         else                e_cg = 1'b1;
      end else begin
         e_cg = bus.core_req;
         e_lg = bus.ld_req;
      end
   endtask

   task automatic check_model();
      logic exp_crv, exp_lrv;
      logic [31:0] exp_rd;
      model_grants();
      exp_crv = 1'b0;
      exp_lrv = 1'b0;
      exp_rd  = 32'd0;
      if (!rst && pend_q.size() > 0 && pend_q[0].due == cyc) begin
         if (pend_q[0].owner) exp_lrv = 1'b1;
         else                 exp_crv = 1'b1;
         exp_rd = pend_q[0].data;
      end
      chk("core_gnt", bus.core_gnt, e_cg);
      chk("ld_gnt", bus.ld_gnt, e_lg);
      chk("core_stall", bus.core_stall, bus.core_req & ~e_cg);
      chk("ram_en", bus.ram_en, e_cg | e_lg);
      if (e_cg) begin
         chk("ram_we_core", bus.ram_we, bus.core_we);
         chk("ram_addr_core", bus.ram_addr, bus.core_addr);
         if (bus.core_we) chk("ram_di_core", bus.ram_di, bus.core_wdata);
      end else if (e_lg) begin
         chk("ram_we_ld", bus.ram_we, bus.ld_we);
         chk("ram_addr_ld", bus.ram_addr, bus.ld_addr);
         if (bus.ld_we) chk("ram_di_ld", bus.ram_di, bus.ld_wdata);
      end else begin
         chk("ram_we_idle", bus.ram_we, 1'b0);
      end
      chk("core_rvalid", bus.core_rvalid, exp_crv);
      chk("ld_rvalid", bus.ld_rvalid, exp_lrv);
      chk("rvalid_excl", bus.core_rvalid & bus.ld_rvalid, 1'b0);
      if (exp_crv || exp_lrv) chk("rdata", bus.rdata, exp_rd);
      chk("booting", bus.booting, !m_run);
   endtask

   task automatic commit();
      ret_t r;
      if (rst) begin
         m_run  = 1'b0;
         m_wait = 0;
         pend_q.delete();
      end else begin
         if (pend_q.size() > 0 && pend_q[0].due == cyc) void'(pend_q.pop_front());
         if (m_run && bus.ld_req && !e_lg) m_wait++;
         else                               m_wait = 0;
         if (e_cg) begin
            if (bus.core_we) exp_mem[bus.core_addr[7:2]] = bus.core_wdata;
            else begin
               r.due = cyc + 1; r.owner = 1'b0; r.data = exp_mem[bus.core_addr[7:2]];
               pend_q.push_back(r);
            end
         end else if (e_lg) begin
            if (bus.ld_we) exp_mem[bus.ld_addr[7:2]] = bus.ld_wdata;
            else begin
               r.due = cyc + 1; r.owner = 1'b1; r.data = exp_mem[bus.ld_addr[7:2]];
               pend_q.push_back(r);
            end
         end
         if (!m_run && bus.ld_done) m_run = 1'b1;
      end
      cyc++;
   endtask

   task automatic advance();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic drive(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                        input logic [31:0] cd, input bit lr, input bit lw,
                        input logic [31:0] la, input logic [31:0] ldv, input bit dn);
      rst            = r;
      bus.core_req   = cr;
      bus.core_we    = cw;
      bus.core_addr  = ca;
      bus.core_wdata = cd;
      bus.ld_req     = lr;
      bus.ld_we      = lw;
      bus.ld_addr    = la;
      bus.ld_wdata   = ldv;
      bus.ld_done    = dn;
   endtask

   // one cycle: settle, check against the model, advance
   task automatic step();
      #4;
      check_model();
      advance();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        r, cr, cw;
      logic [31:0] ca, cd;
      logic        lr, lw;
      logic [31:0] la, ldv;
      logic        dn;
      logic        e_cg, e_lg, e_boot, e_crv, e_lrv;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                               input logic lr, input logic lw, input logic [31:0] la,
                               input logic [31:0] ldv, input logic dn, input logic ecg,
                               input logic elg, input logic eb, input logic ecrv, input logic elrv);
      vec_t v;
      v.r = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = 32'd0;
      v.lr = lr; v.lw = lw; v.la = la; v.ldv = ldv; v.dn = dn;
      v.e_cg = ecg; v.e_lg = elg; v.e_boot = eb; v.e_crv = ecrv; v.e_lrv = elrv;
      return v;
   endfunction

   vec_t vecs [0:13];

   initial begin : main
      bit          c_act, c_we, l_act, l_we, rr, dn;
      logic [31:0] c_addr, c_data, l_addr, l_data;

      for (int i = 0; i < 64; i++) exp_mem[i] = 32'd0;
      m_run  = 1'b0;
      m_wait = 0;
      ram_clear = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      ram_clear = 1'b0;

      // boot load of 8 words with the core waiting, then RUN read-return routing
      vecs[0] = mk(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[1] = vecs[0];
      for (int i = 0; i < 8; i++)
         vecs[2+i] = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'(i*4), 32'hA000_0000 + 32'(i),
                        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].r, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
               vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].ldv, vecs[i].dn);
         #4;
         chk($sformatf("vec%0d_core_gnt", i), bus.core_gnt, vecs[i].e_cg);
         chk($sformatf("vec%0d_ld_gnt", i), bus.ld_gnt, vecs[i].e_lg);
         chk($sformatf("vec%0d_booting", i), bus.booting, vecs[i].e_boot);
         chk($sformatf("vec%0d_core_rvalid", i), bus.core_rvalid, vecs[i].e_crv);
         chk($sformatf("vec%0d_ld_rvalid", i), bus.ld_rvalid, vecs[i].e_lrv);
         if (i == 12) chk("vec12_rdata", bus.rdata, 32'hA000_0004);
         if (i == 13) chk("vec13_rdata", bus.rdata, 32'hA000_0005);
         check_model();
         advance();
      end

      // starvation bound: both request every cycle, loader wins every fifth cycle
      for (int k = 0; k < 15; k++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h30, 32'h5555_0000, 1'b0);
         #4;
         chk($sformatf("starve%0d_ld_gnt", k), bus.ld_gnt, (k % 5) == 4);
         chk($sformatf("starve%0d_core_gnt", k), bus.core_gnt, (k % 5) != 4);
         check_model();
         advance();
      end

      // ld_done together with ld_req in BOOT, core waiting
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h18, 32'h1111, 1'b1);
      #4;
      chk("simul_ld_gnt", bus.ld_gnt, 1'b1);
      chk("simul_core_gnt", bus.core_gnt, 1'b0);
      check_model();
      advance();
      drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h1C, 32'h2222, 1'b0);
      #4;
      chk("simul_next_booting", bus.booting, 1'b0);
      chk("simul_next_core_gnt", bus.core_gnt, 1'b1);
      chk("simul_next_ld_gnt", bus.ld_gnt, 1'b0);
      check_model();
      advance();
      drive(1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h1C, 32'h2222, 1'b0);
      step();

      // reset arriving the cycle after a granted core load
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("rstrd_core_gnt", bus.core_gnt, 1'b1);
      check_model();
      advance();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("rstrd_n1_core_rvalid", bus.core_rvalid, 1'b0);
      chk("rstrd_n1_ram_en", bus.ram_en, 1'b0);
      check_model();
      advance();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("rstrd_n2_core_rvalid", bus.core_rvalid, 1'b0);
      chk("rstrd_n2_booting", bus.booting, 1'b1);
      check_model();
      advance();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step();

      // store then load back-to-back to the same word
      drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("stld_st_ram_we", bus.ram_we, 1'b1);
      chk("stld_st_core_gnt", bus.core_gnt, 1'b1);
      check_model();
      advance();
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("stld_ld_ram_we", bus.ram_we, 1'b0);
      chk("stld_ld_core_gnt", bus.core_gnt, 1'b1);
      check_model();
      advance();
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #4;
      chk("stld_core_rvalid", bus.core_rvalid, 1'b1);
      chk("stld_rdata", bus.rdata, 32'hDEAD_BEEF);
      check_model();
      advance();

      // random traffic; requests hold their fields until the model grants them
      c_act = 1'b0; l_act = 1'b0;
      c_we = 1'b0; l_we = 1'b0;
      c_addr = 32'd0; c_data = 32'd0; l_addr = 32'd0; l_data = 32'd0;
      for (int n = 0; n < 2000; n++) begin
         if (!c_act && $urandom_range(0, 99) < 60) begin
            c_act  = 1'b1;
            c_we   = $urandom_range(0, 1) == 1;
            c_addr = 32'($urandom_range(0, 63)) << 2;
            c_data = $urandom;
         end
         if (!l_act && $urandom_range(0, 99) < 50) begin
            l_act  = 1'b1;
            l_we   = $urandom_range(0, 1) == 1;
            l_addr = 32'($urandom_range(0, 63)) << 2;
            l_data = $urandom;
         end
         rr = $urandom_range(0, 199) == 0;
         dn = $urandom_range(0, 19) == 0;
         drive(rr, c_act, c_we, c_addr, c_data, l_act, l_we, l_addr, l_data, dn);
         #4;
         check_model();
         if (e_cg) c_act = 1'b0;
         if (e_lg) l_act = 1'b0;
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data block RAM between the core's load/store stage and the UART program loader. It holds the core off during boot, then arbitrates each cycle with core priority and a bounded-starvation guarantee for the loader. It also routes the one-cycle-latency read data back to whichever requester issued the read. It sits between exec/mem_pipe, the loader and block_ram, and drives the memory stall term into the core's stall logic.

## Interface
- Reset rst, synchronous, active-high; clock clk.
- Parameter STARVE_MAX, default 4: consecutive denied loader requests after which the loader wins the next contended cycle; legal range 1..15.
- Parameter AW, default 32: address width.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  byte address
- core_wdata  in  32  store data
- core_gnt  out  1  access issued to RAM this cycle
- core_stall  out  1  core_req && !core_gnt
- core_rvalid  out  1  core load data valid on rdata
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/32  loader request, same meaning as the core fields
- ld_gnt  out  1  loader access issued this cycle
- ld_rvalid  out  1  loader load data valid on rdata
- ld_done  in  1  one-cycle pulse: image fully written
- rdata  out  32  read data, broadcast to both requesters; qualify with the matching rvalid
- booting  out  1  1 while in BOOT
- ram_en, ram_we  out  1/1  block RAM enable and write enable
- ram_addr  out  AW  block RAM address
- ram_di  out  32  block RAM write data
- ram_dout  in  32  block RAM read data, valid 1 cycle after an enabled read

## Operation
- FSM has two states, BOOT and RUN. Reset enters BOOT.
- BOOT: only the loader is granted (ld_gnt = ld_req); core_gnt = 0.
- BOOT -> RUN on ld_done. If ld_done and ld_req arrive together, that ld_req is still granted in BOOT.
- RUN: ld_done is ignored. No path back to BOOT except rst.
- RUN grant rules:
  - Core only requesting: core granted.
  - Loader only requesting: loader granted.
  - Both requesting: core granted unless starve_cnt == STARVE_MAX, in which case the loader is granted.
- starve_cnt (4 bits):
  - In RUN, +1 when ld_req && !ld_gnt, saturating at STARVE_MAX.
  - Cleared to 0 when ld_gnt, when !ld_req, and always in BOOT.
- RAM drive:
  - ram_en = core_gnt | ld_gnt. At most one grant per cycle.
  - ram_we, ram_addr, ram_di are muxed from the granted requester.
  - With no grant, ram_en = 0 and ram_we = 0; ram_addr and ram_di are don't-care.
- Read return:
  - A granted load registers rd_pend = 1 and rd_owner (0 = core, 1 = loader).
  - Next cycle the owner's rvalid is 1; rdata = ram_dout.
  - Stores produce no rvalid.
  - Back-to-back loads are supported; each grant produces exactly one rvalid, in order.
- Grants are combinational from the request inputs and registered state. Requesters must not change addr/we/wdata while req is high and ungranted.

## Timing
- Reset values: state BOOT; starve_cnt 0; rd_pend 0; core_rvalid 0; ld_rvalid 0; booting 1.
- During any cycle with rst high, both grants are forced 0 and ram_en = 0.
- Grant latency: 0 cycles, same cycle as the request when uncontended.
- Read latency: rvalid exactly 1 cycle after the granting cycle.
- Maximum loader wait in RUN under continuous core traffic: STARVE_MAX + 1 cycles from ld_req to ld_gnt.
- Reset in the cycle after a granted load: no rvalid is produced, and the pending read is discarded.
- core_stall is combinational. It is high throughout BOOT whenever core_req = 1.

## Test plan
- Boot load: assert rst, write 8 words via the loader to addresses 0x0..0x1C with core_req = 1 throughout.
  - Required: ld_gnt every cycle; core_gnt = 0; core_stall = 1; booting = 1.
  - After ld_done: booting = 0 next cycle, and the core is granted the following cycle.
- Read return routing in RUN:
  - Core loads 0x10, then the loader loads 0x14 on the next cycle.
  - Required: core_rvalid one cycle after core_gnt with the value stored at 0x10; then ld_rvalid with the value at 0x14.
  - core_rvalid and ld_rvalid are never high together.
- Starvation bound, STARVE_MAX = 4: core_req and ld_req held high continuously.
  - Required: 4 core grants, then 1 ld_gnt, then starve_cnt = 0, repeating with period 5.
- Simultaneous events: ld_done and ld_req in the same BOOT cycle with core_req high.
  - Required: that cycle ld_gnt = 1 and core_gnt = 0; next cycle state is RUN and the core wins over the loader.
- Reset mid-read: core load granted at cycle N, rst asserted at N+1.
  - Required: core_rvalid = 0 at N+1 and N+2; booting = 1 from N+2; ram_en = 0 during N+1.
- Store/load ordering: the core stores 0xDEADBEEF to 0x40, then loads 0x40 back-to-back.
  - Required: ram_we = 1 on the first cycle, then 0; the load returns 0xDEADBEEF with core_rvalid = 1 on the third cycle.
